// File: rtl/reg_bank.sv
// reg_bank: 32-entry register file with two combinational read ports, one write port and a sticky bad-index flag.
// Optional build macro REG_BANK_BYPASS_EN forwards same-cycle write data to matching read ports.
//
// addr_err state | meaning
// ERR_CLEAN      | no illegal write seen since reset
// ERR_SET        | an illegal write index was seen; held until reset
module reg_bank #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(227),
    parameter logic [DATA_W-1:0]  RA_INIT = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [4:0]        ReadReg1,
    input  logic [4:0]        ReadReg2,
    input  logic [31:0]       WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              addr_err
);

    typedef enum logic {
        ERR_CLEAN = 1'b0,
        ERR_SET   = 1'b1
    } err_state_t;

    err_state_t        err_state, err_next;
    logic [DATA_W-1:0] regs [32];
    logic              idx_legal;
    logic              wr_hit;
    logic [4:0]        wr_idx;

    assign idx_legal = (WriteReg[31:5] == 27'd0);
    assign wr_idx    = WriteReg[4:0];
    // Writes to r0 are legal but never land; r0 stays at its reset value of 0.
    assign wr_hit    = RegWrite && idx_legal && (wr_idx != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            regs[29] <= SP_INIT;
            regs[31] <= RA_INIT;
        end else if (wr_hit) begin
            regs[wr_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_state <= ERR_CLEAN;
        end else begin
            err_state <= err_next;
        end
    end

    always_comb begin
        err_next = err_state;
        if (RegWrite && !idx_legal) begin
            err_next = ERR_SET;
        end
    end

    assign addr_err = (err_state == ERR_SET);

    always_comb begin
        ReadData1 = (ReadReg1 == 5'd0) ? '0 : regs[ReadReg1];
        ReadData2 = (ReadReg2 == 5'd0) ? '0 : regs[ReadReg2];
`ifdef REG_BANK_BYPASS_EN
        // wr_hit already excludes r0 and illegal indices; reset suppresses forwarding.
        if (wr_hit && !reset && (ReadReg1 == wr_idx)) begin
            ReadData1 = WriteData;
        end
        if (wr_hit && !reset && (ReadReg2 == wr_idx)) begin
            ReadData2 = WriteData;
        end
`else
`endif
    end

endmodule
